prbs22_checker: RTL and testbench

Serial PRBS-22 checker: the receive end of the 22-bit Fibonacci LFSR pattern generator, polynomial x^22 + x^21 + 1, new bit = s[21] ^ s[20], shifted into s[0].
- Self-synchronises to the incoming bit stream, then predicts each following bit locally.
- Counts mismatches and reports lock status, giving the DSP datapath a built-in bit-error-rate monitor on any link or loopback that carries the generator output.

---
 rtl/prbs_pkg.sv | 20 ++
 rtl/prbs22_predict.sv | 11 +
 rtl/prbs22_checker.sv | 155 +++++++++++++++
 tb/tb_prbs22_checker.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS-22 definitions: checker states, polynomial taps and the generator seed.
package prbs_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int PRBS_LEN = 22;
  localparam int TAP_A    = 21;
  localparam int TAP_B    = 20;

  localparam logic [PRBS_LEN-1:0] PRBS_SEED = 22'h2FFFFF;

  function automatic logic prbs_next(input logic [PRBS_LEN-1:0] s);
    return s[TAP_A] ^ s[TAP_B];
  endfunction

endpackage

// File: rtl/prbs22_predict.sv
// Combinational next-bit predictor for the x^22 + x^21 + 1 Fibonacci LFSR.
module prbs22_predict
  import prbs_pkg::*;
(
  input  logic [PRBS_LEN-1:0] sr,
  output logic                p
);

  assign p = prbs_next(sr);

endmodule

// File: rtl/prbs22_checker.sv
// Serial PRBS-22 checker: HUNT/VERIFY/LOCKED sync FSM with saturating error and bit counters.
// Optional loss-of-lock window monitor enabled by defining PRBS_CHK_LOL_EN.
module prbs22_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_MATCHES = 64,
  parameter int ERR_W        = 16,
  parameter int BIT_W        = 32,
  parameter int LOL_WIN      = 1024,
  parameter int LOL_ERRS     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             resync,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [BIT_W-1:0] bit_count
);

  localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam int FILL_W  = $clog2(PRBS_LEN + 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCHES - 1);
  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(PRBS_LEN - 1);

  state_t              state_r;
  logic [PRBS_LEN-1:0] sr_r;
  logic [FILL_W-1:0]   fill_r;
  logic [MATCH_W-1:0]  match_r;

  logic                p_s;
  logic                miss_s;
  logic                lol_s;
  logic [PRBS_LEN-1:0] sr_in_s;
  logic [ERR_W-1:0]    err_sat_s;
  logic [BIT_W-1:0]    bit_sat_s;

  prbs22_predict u_predict (
    .sr (sr_r),
    .p  (p_s)
  );

  assign miss_s    = in_bit ^ p_s;
  assign sr_in_s   = {sr_r[PRBS_LEN-2:0], in_bit};
  // Increment by one unless already all-ones, so the counters stick at max.
  assign err_sat_s = err_count + {{(ERR_W-1){1'b0}}, ~&err_count};
  assign bit_sat_s = bit_count + {{(BIT_W-1){1'b0}}, ~&bit_count};

`ifdef PRBS_CHK_LOL_EN
  localparam int WIN_W  = $clog2(LOL_WIN + 1);
  localparam int ERRS_W = $clog2(LOL_ERRS + 1);

  logic [WIN_W-1:0]  win_cnt_r;
  logic [ERRS_W-1:0] win_err_r;

  assign lol_s = (state_r == LOCKED) && in_valid && miss_s &&
                 (win_err_r == ERRS_W'(LOL_ERRS - 1));

  // Loss-of-lock window: bits and errors seen since the window last restarted.
  always_ff @(posedge clk) begin
    if (reset || resync || (state_r != LOCKED) || lol_s) begin
      win_cnt_r <= '0;
      win_err_r <= '0;
    end else if (in_valid) begin
      if (win_cnt_r == WIN_W'(LOL_WIN - 1)) begin
        win_cnt_r <= '0;
        win_err_r <= '0;
      end else begin
        win_cnt_r <= win_cnt_r + WIN_W'(1);
        win_err_r <= win_err_r + ERRS_W'(miss_s);
      end
    end
  end
`else
  assign lol_s = 1'b0;
`endif

  // Sync FSM, shift register and registered status/counter outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= HUNT;
      sr_r      <= '0;
      fill_r    <= '0;
      match_r   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else if (resync) begin
      // sr is kept so a restarted stream never looks like the all-zero lock-up state.
      state_r   <= HUNT;
      fill_r    <= '0;
      match_r   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        case (state_r)
          HUNT: begin
            sr_r <= sr_in_s;
            if (sr_in_s == '0) begin
              fill_r <= '0;
            end else if (fill_r == FILL_LAST) begin
              state_r <= VERIFY;
              fill_r  <= '0;
              match_r <= '0;
            end else begin
              fill_r <= fill_r + FILL_W'(1);
            end
          end
          VERIFY: begin
            sr_r <= sr_in_s;
            if (miss_s) begin
              state_r <= HUNT;
              fill_r  <= '0;
            end else if (match_r == MATCH_LAST) begin
              state_r <= LOCKED;
              locked  <= 1'b1;
            end else begin
              match_r <= match_r + MATCH_W'(1);
            end
          end
          LOCKED: begin
            // Free-run on the prediction so one line error costs exactly one miss.
            sr_r      <= {sr_r[PRBS_LEN-2:0], p_s};
            bit_count <= bit_sat_s;
            if (miss_s) begin
              err_pulse <= 1'b1;
              err_count <= err_sat_s;
            end
            if (lol_s) begin
              state_r <= HUNT;
              fill_r  <= '0;
              locked  <= 1'b0;
            end
          end
          default: begin
            state_r <= HUNT;
            fill_r  <= '0;
            locked  <= 1'b0;
          end
        endcase
      end
      if (clear) begin
        err_count <= '0;
        bit_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs22_checker.sv
// Directed bench for prbs22_checker; ERR_W is narrowed to 8 so saturation is reachable quickly.
// Expectations for the inverted-stream case follow PRBS_CHK_LOL_EN.
module tb_prbs22_checker;
  import prbs_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        resync = 1'b0;
  logic        clear = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [31:0] bit_count;

  logic [21:0] gen_r;
  int          vectors = 0;
  int          miscompares = 0;

  prbs22_checker #(
    .LOCK_MATCHES (64),
    .ERR_W        (8),
    .BIT_W        (32),
    .LOL_WIN      (1024),
    .LOL_ERRS     (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .resync    (resync),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are stable 1 time unit after the edge.
  task automatic send(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    resync   = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic next_gen(output logic b);
    gen_r = {gen_r[20:0], gen_r[21] ^ gen_r[20]};
    b     = gen_r[0];
  endtask

  // n valid generator bits, optionally inverted, optionally with an idle cycle before each.
  task automatic send_gen(input int n, input logic inv, input logic toggle);
    logic b;
    for (int i = 0; i < n; i++) begin
      if (toggle) send(1'b0, 1'($urandom_range(1, 0)));
      next_gen(b);
      send(1'b1, b ^ inv);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    send(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    logic b;
    do_reset();
    check("rst_locked", locked, 0);
    check("rst_errp", err_pulse, 0);
    check("rst_errc", err_count, 0);
    check("rst_bitc", bit_count, 0);

    // Clean lock: 86 valid bits from the seeded generator.
    gen_r = PRBS_SEED;
    send_gen(85, 1'b0, 1'b0);
    check("lock_85", locked, 0);
    send_gen(1, 1'b0, 1'b0);
    check("lock_86", locked, 1);
    check("lock_errc", err_count, 0);
    check("lock_bitc", bit_count, 0);
    send_gen(10, 1'b0, 1'b0);
    check("bitc_10", bit_count, 10);
    send_gen(1, 1'b0, 1'b0);
    check("bitc_11", bit_count, 11);

    // Single line error.
    next_gen(b);
    send(1'b1, ~b);
    check("err1_pulse", err_pulse, 1);
    check("err1_count", err_count, 1);
    check("err1_locked", locked, 1);
    send_gen(1, 1'b0, 1'b0);
    check("err1_pulse_off", err_pulse, 0);
    send_gen(20, 1'b0, 1'b0);
    check("err1_count_hold", err_count, 1);
    check("err1_bitc", bit_count, 33);

    // Build err_count up to 5, then clear on the same edge as an error.
    for (int k = 0; k < 4; k++) begin
      next_gen(b);
      send(1'b1, ~b);
      send_gen(3, 1'b0, 1'b0);
    end
    check("err5_count", err_count, 5);
    next_gen(b);
    clear = 1'b1;
    send(1'b1, ~b);
    check("clr_errc", err_count, 0);
    check("clr_errp", err_pulse, 1);
    check("clr_bitc", bit_count, 0);
    send_gen(5, 1'b0, 1'b0);
    check("clr_bitc5", bit_count, 5);
    check("clr_errc5", err_count, 0);

    // Inverted stream from a fresh lock.
    do_reset();
    gen_r = PRBS_SEED;
    send_gen(86, 1'b0, 1'b0);
    check("inv_lock", locked, 1);
    send_gen(15, 1'b1, 1'b0);
    check("inv15_locked", locked, 1);
    check("inv15_errc", err_count, 15);
    send_gen(1, 1'b1, 1'b0);
    check("inv16_errc", err_count, 16);
`ifdef PRBS_CHK_LOL_EN
    check("lol_locked", locked, 0);
`else
    check("inv16_locked", locked, 1);
    send_gen(250, 1'b1, 1'b0);
    check("sat_errc", err_count, 255);
    check("sat_errp", err_pulse, 1);
    check("sat_locked", locked, 1);
`endif

    // Zero stream never locks, then the seeded generator locks in 86 bits.
    do_reset();
    for (int i = 0; i < 200; i++) send(1'b1, 1'b0);
    check("zero_locked", locked, 0);
    check("zero_errc", err_count, 0);
    check("zero_bitc", bit_count, 0);
    gen_r = PRBS_SEED;
    send_gen(85, 1'b0, 1'b0);
    check("zlock_85", locked, 0);
    send_gen(1, 1'b0, 1'b0);
    check("zlock_86", locked, 1);

    // Reset mid-LOCKED with 50% valid.
    send_gen(10, 1'b0, 1'b1);
    check("tog_bitc", bit_count, 10);
    next_gen(b);
    send(1'b1, ~b);
    check("tog_errc", err_count, 1);
    do_reset();
    check("mid_rst_locked", locked, 0);
    check("mid_rst_errp", err_pulse, 0);
    check("mid_rst_errc", err_count, 0);
    check("mid_rst_bitc", bit_count, 0);

    // Resync keeps counters and relocks after 86 valid bits.
    gen_r = PRBS_SEED;
    send_gen(85, 1'b0, 1'b1);
    check("tlock_85", locked, 0);
    send_gen(1, 1'b0, 1'b1);
    check("tlock_86", locked, 1);
    next_gen(b);
    send(1'b1, ~b);
    send_gen(9, 1'b0, 1'b1);
    check("pre_rs_errc", err_count, 1);
    check("pre_rs_bitc", bit_count, 10);
    resync = 1'b1;
    send(1'b0, 1'b0);
    check("rs_locked", locked, 0);
    check("rs_errc", err_count, 1);
    check("rs_bitc", bit_count, 10);
    send_gen(85, 1'b0, 1'b1);
    check("rlock_85", locked, 0);
    send_gen(1, 1'b0, 1'b1);
    check("rlock_86", locked, 1);
    check("rlock_bitc", bit_count, 10);
    check("rlock_errc", err_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
